// File: rtl/result_arbiter_pkg.sv
// Shared types and widths for the result arbiter: default geometry, the
// held-word state encoding and a small width helper used by the sub-blocks.
package result_arbiter_pkg;

    localparam int NREQ_DEF   = 4;
    localparam int ID_W_DEF   = 2;
    localparam int DATA_W_DEF = 14;
    localparam int FIFO_W     = ID_W_DEF + DATA_W_DEF;
    localparam int STALL_W    = 16;

    // Output register occupancy: EMPTY = no word pending, HELD = word on fifo_wr_port
    typedef enum logic {
        EMPTY = 1'b0,
        HELD  = 1'b1
    } hold_state_e;

    // Width of an index able to address n requesters (never below one bit)
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/result_arbiter_if.sv
// Bundle of the core-array request side and the fifo write side of the
// result arbiter. "slave" is the arbiter's view, "master" the environment's.
interface result_arbiter_if
    import result_arbiter_pkg::*;
#(
    parameter int NREQ   = NREQ_DEF,
    parameter int ID_W   = ID_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);

    logic [NREQ-1:0]        req;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [NREQ-1:0]        ack;
    logic [ID_W+DATA_W-1:0] fifo_wr_port;
    logic                   fifo_wr_req;
    logic                   fifo_q_full;
    logic [STALL_W-1:0]     stall_cnt;

    modport master (
        output req,
        output req_data,
        output fifo_q_full,
        input  ack,
        input  fifo_wr_port,
        input  fifo_wr_req,
        input  stall_cnt
    );

    modport slave (
        input  req,
        input  req_data,
        input  fifo_q_full,
        output ack,
        output fifo_wr_port,
        output fifo_wr_req,
        output stall_cnt
    );

endinterface

// File: rtl/result_arbiter_rr_pick.sv
// Combinational round-robin picker: finds the first asserted request after
// the previous winner, wrapping around, and reports it as one-hot and index.
module result_arbiter_rr_pick
    import result_arbiter_pkg::*;
#(
    parameter  int NREQ  = NREQ_DEF,
    localparam int IDX_W = idx_width(NREQ)
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] last_grant_i,
    output logic [NREQ-1:0]  grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    int               cand;
    logic [IDX_W-1:0] cand_idx;

    // Scan last_grant+1 .. last_grant+NREQ (mod NREQ); the first hit wins
    always_comb begin
        grant_o  = '0;
        idx_o    = '0;
        any_o    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = int'(last_grant_i) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            cand_idx = IDX_W'(cand);
            if (!any_o && req_i[cand_idx]) begin
                any_o             = 1'b1;
                grant_o[cand_idx] = 1'b1;
                idx_o             = cand_idx;
            end
        end
    end

endmodule

// File: rtl/result_arbiter.sv
// Result arbiter: shares the single fifo write port between NREQ cores.
// One output register holds the granted {id, data} word until the fifo
// takes it; a new word can be captured in the same cycle the old one leaves.
module result_arbiter
    import result_arbiter_pkg::*;
#(
    parameter int NREQ   = NREQ_DEF,
    parameter int ID_W   = ID_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    result_arbiter_if.slave  bus
);

    localparam int               IDX_W    = idx_width(NREQ);
    localparam int               FW       = ID_W + DATA_W;
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NREQ - 1);

    // Saturating increment: the stall counter sticks at all-ones
    function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
        return (v == {STALL_W{1'b1}}) ? v : v + STALL_W'(1);
    endfunction

    hold_state_e        state_q, state_d;
    logic [FW-1:0]      word_q,  word_d;
    logic [IDX_W-1:0]   last_q,  last_d;
    logic [STALL_W-1:0] stall_q, stall_d;

    logic [DATA_W-1:0]  data_arr [NREQ];
    logic [NREQ-1:0]    pick_grant;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic               out_valid;
    logic               accept;
    logic               slot_free;
    logic               grant_en;

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign data_arr[g] = bus.req_data[g*DATA_W +: DATA_W];
    end

    result_arbiter_rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req_i        (bus.req),
        .last_grant_i (last_q),
        .grant_o      (pick_grant),
        .idx_o        (pick_idx),
        .any_o        (pick_any)
    );

    // accept mirrors the fifo's own write condition, so a word leaves exactly once
    assign out_valid = (state_q == HELD);
    assign accept    = out_valid & ~bus.fifo_q_full;
    assign slot_free = ~out_valid | accept;
    assign grant_en  = slot_free & pick_any & ~reset;

    assign bus.ack          = grant_en ? pick_grant : '0;
    assign bus.fifo_wr_port = word_q;
    assign bus.fifo_wr_req  = out_valid;
    assign bus.stall_cnt    = stall_q;

    // Next state: capture a granted word, release an accepted one, count stalls
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        last_d  = last_q;
        stall_d = stall_q;
        if (out_valid && bus.fifo_q_full) begin
            stall_d = sat_inc(stall_q);
        end
        if (grant_en) begin
            state_d = HELD;
            word_d  = {ID_W'(pick_idx), data_arr[pick_idx]};
            last_d  = pick_idx;
        end else if (accept) begin
            state_d = EMPTY;
        end
    end

    // State register; reset drops any held word and restarts round-robin at core 0
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            word_q  <= '0;
            last_q  <= LAST_RST;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            last_q  <= last_d;
            stall_q <= stall_d;
        end
    end

endmodule

// File: tb/tb_result_arbiter.sv
// Testbench for result_arbiter: directed scenarios plus a randomized run,
// all compared against a transaction-level reference model of the arbiter.
module tb_result_arbiter;

    localparam int NREQ   = 4;
    localparam int ID_W   = 2;
    localparam int DATA_W = 14;
    localparam int FW     = ID_W + DATA_W;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    result_arbiter_if #(.NREQ(NREQ), .ID_W(ID_W), .DATA_W(DATA_W)) bus ();

    result_arbiter #(.NREQ(NREQ), .ID_W(ID_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [DATA_W-1:0] dv [NREQ];

    // Reference model: the word register, previous winner and stall count
    logic          m_valid = 1'b0;
    logic [FW-1:0] m_word  = '0;
    int            m_last  = NREQ - 1;
    logic [15:0]   m_stall = '0;

    function automatic int pick();
        int c;
        if (reset) return -1;
        if (m_valid && bus.fifo_q_full) return -1;
        for (int k = 1; k <= NREQ; k++) begin
            c = (m_last + k) % NREQ;
            if (bus.req[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] exp_ack();
        logic [NREQ-1:0] r;
        int p;
        r = '0;
        p = pick();
        if (p >= 0) r[p] = 1'b1;
        return r;
    endfunction

    always @(posedge clk) begin
        int p;
        p = pick();
        if (reset) begin
            m_valid = 1'b0;
            m_word  = '0;
            m_last  = NREQ - 1;
            m_stall = '0;
        end else begin
            if (m_valid && bus.fifo_q_full && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
            if (p >= 0) begin
                m_word  = {ID_W'(p), bus.req_data[p*DATA_W +: DATA_W]};
                m_valid = 1'b1;
                m_last  = p;
            end else if (m_valid && !bus.fifo_q_full) begin
                m_valid = 1'b0;
            end
        end
    end

    task automatic put_data(input int i, input logic [DATA_W-1:0] v);
        dv[i] = v;
        bus.req_data[i*DATA_W +: DATA_W] = v;
    endtask

    task automatic test_reset();
        bus.req = '0;
        bus.req_data = '0;
        bus.fifo_q_full = 1'b0;
        for (int i = 0; i < NREQ; i++) dv[i] = '0;
        reset = 1'b1;
        @(posedge clk); #2;
        #2;
        checks++;
        if (bus.fifo_wr_req !== 1'b0 || bus.ack !== 4'b0000) begin
            errors++; $display("FAIL reset_hold wr_req=%b ack=%b expected 0/0000", bus.fifo_wr_req, bus.ack);
        end
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #2;
            #2;
            checks++;
            if (bus.fifo_wr_req !== 1'b0 || bus.ack !== 4'b0000 || bus.stall_cnt !== 16'd0 || bus.fifo_wr_port !== 16'd0) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d wr_req=%b ack=%b stall=%0d port=%h expected 0/0000/0/0000",
                         k, bus.fifo_wr_req, bus.ack, bus.stall_cnt, bus.fifo_wr_port);
            end
        end
    endtask

    task automatic test_round_robin();
        int prev;
        logic [DATA_W-1:0] prev_data;
        logic [NREQ-1:0] want;
        prev = -1;
        prev_data = '0;
        for (int i = 0; i < NREQ; i++) put_data(i, DATA_W'($urandom));
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #2;
            if (prev >= 0) put_data(prev, DATA_W'($urandom));
            bus.req = 4'b1111;
            bus.fifo_q_full = 1'b0;
            #2;
            want = 4'b0001 << (k % NREQ);
            checks++;
            if (bus.ack !== want) begin
                errors++; $display("FAIL rr_ack cyc=%0d got=%b expected=%b", k, bus.ack, want);
            end
            if (prev >= 0) begin
                checks++;
                if (bus.fifo_wr_req !== 1'b1 || bus.fifo_wr_port !== {ID_W'(prev), prev_data}) begin
                    errors++;
                    $display("FAIL rr_port cyc=%0d wr_req=%b port=%h expected 1/%h",
                             k, bus.fifo_wr_req, bus.fifo_wr_port, {ID_W'(prev), prev_data});
                end
            end
            prev = k % NREQ;
            prev_data = dv[prev];
        end
        @(posedge clk); #2;
        bus.req = '0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_single();
        @(posedge clk); #2;
        put_data(2, 14'h1ABC);
        bus.req = 4'b0100;
        #2;
        checks++;
        if (bus.ack !== 4'b0100) begin
            errors++; $display("FAIL single_ack got=%b expected=0100", bus.ack);
        end
        @(posedge clk); #2;
        bus.req = '0;
        #2;
        checks++;
        if (bus.fifo_wr_req !== 1'b1 || bus.fifo_wr_port !== {2'd2, 14'h1ABC} || bus.ack !== 4'b0000) begin
            errors++;
            $display("FAIL single_word wr_req=%b port=%h ack=%b expected 1/%h/0000",
                     bus.fifo_wr_req, bus.fifo_wr_port, bus.ack, {2'd2, 14'h1ABC});
        end
        @(posedge clk); #2;
        #2;
        checks++;
        if (bus.fifo_wr_req !== 1'b0) begin
            errors++; $display("FAIL single_once wr_req=%b expected=0", bus.fifo_wr_req);
        end
    endtask

    task automatic test_full_stall();
        logic [DATA_W-1:0] d0, d1;
        d0 = DATA_W'($urandom);
        d1 = DATA_W'($urandom);
        @(posedge clk); #2;
        put_data(0, d0);
        put_data(1, d1);
        bus.req = 4'b0011;
        bus.fifo_q_full = 1'b0;
        #2;
        checks++;
        if (bus.ack !== 4'b0001) begin
            errors++; $display("FAIL stall_first_ack got=%b expected=0001", bus.ack);
        end
        for (int j = 0; j < 3; j++) begin
            @(posedge clk); #2;
            bus.fifo_q_full = 1'b1;
            #2;
            checks++;
            if (bus.ack !== 4'b0000 || bus.fifo_wr_req !== 1'b1 || bus.fifo_wr_port !== {2'd0, d0} || bus.stall_cnt !== 16'(j)) begin
                errors++;
                $display("FAIL stall_hold cyc=%0d ack=%b wr_req=%b port=%h stall=%0d expected 0000/1/%h/%0d",
                         j, bus.ack, bus.fifo_wr_req, bus.fifo_wr_port, bus.stall_cnt, {2'd0, d0}, j);
            end
        end
        @(posedge clk); #2;
        bus.fifo_q_full = 1'b0;
        #2;
        checks++;
        if (bus.stall_cnt !== 16'd3 || bus.ack !== 4'b0010 || bus.fifo_wr_port !== {2'd0, d0}) begin
            errors++;
            $display("FAIL stall_release stall=%0d ack=%b port=%h expected 3/0010/%h",
                     bus.stall_cnt, bus.ack, bus.fifo_wr_port, {2'd0, d0});
        end
        @(posedge clk); #2;
        bus.req = 4'b1111;
        bus.fifo_q_full = 1'b1;
        #2;
        checks++;
        if (bus.fifo_wr_port !== {2'd1, d1} || bus.ack !== 4'b0000 || bus.stall_cnt !== 16'd3) begin
            errors++;
            $display("FAIL stall_next port=%h ack=%b stall=%0d expected %h/0000/3",
                     bus.fifo_wr_port, bus.ack, bus.stall_cnt, {2'd1, d1});
        end
    endtask

    task automatic test_stall_sat();
        int bad_ack;
        bad_ack = 0;
        for (int k = 0; k < 70000; k++) begin
            @(negedge clk);
            if (bus.ack !== 4'b0000) bad_ack++;
        end
        checks++;
        if (bus.stall_cnt !== 16'hFFFF) begin
            errors++; $display("FAIL stall_sat stall=%h expected=FFFF", bus.stall_cnt);
        end
        checks++;
        if (bad_ack !== 0 || bus.fifo_wr_req !== 1'b1 || bus.fifo_wr_port !== {2'd1, dv[1]}) begin
            errors++;
            $display("FAIL stall_sat_hold bad_acks=%0d wr_req=%b port=%h expected 0/1/%h",
                     bad_ack, bus.fifo_wr_req, bus.fifo_wr_port, {2'd1, dv[1]});
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #2;
        reset = 1'b1;
        bus.req = 4'b1111;
        bus.fifo_q_full = 1'b0;
        #2;
        checks++;
        if (bus.ack !== 4'b0000) begin
            errors++; $display("FAIL rst_mid_ack got=%b expected=0000", bus.ack);
        end
        @(posedge clk); #2;
        reset = 1'b0;
        #2;
        checks++;
        if (bus.fifo_wr_req !== 1'b0 || bus.fifo_wr_port !== 16'd0 || bus.stall_cnt !== 16'd0 || bus.ack !== 4'b0001) begin
            errors++;
            $display("FAIL rst_mid_after wr_req=%b port=%h stall=%0d ack=%b expected 0/0000/0/0001",
                     bus.fifo_wr_req, bus.fifo_wr_port, bus.stall_cnt, bus.ack);
        end
        @(posedge clk); #2;
        bus.req = '0;
        #2;
        checks++;
        if (bus.fifo_wr_port !== {2'd0, dv[0]} || bus.fifo_wr_req !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_first port=%h wr_req=%b expected %h/1", bus.fifo_wr_port, bus.fifo_wr_req, {2'd0, dv[0]});
        end
    endtask

    task automatic test_random();
        logic [NREQ-1:0] pending, last_ack, want;
        int waited [NREQ];
        pending = '0;
        last_ack = '0;
        for (int i = 0; i < NREQ; i++) waited[i] = 0;
        for (int k = 0; k < 400; k++) begin
            @(posedge clk); #2;
            for (int i = 0; i < NREQ; i++) begin
                if (last_ack[i]) begin
                    pending[i] = ($urandom % 2) == 0;
                    put_data(i, DATA_W'($urandom));
                end else if (!pending[i] && ($urandom % 3) == 0) begin
                    pending[i] = 1'b1;
                    put_data(i, DATA_W'($urandom));
                end
            end
            bus.req = pending;
            bus.fifo_q_full = ($urandom % 100) < 30;
            #2;
            want = exp_ack();
            checks++;
            if (bus.ack !== want) begin
                errors++; $display("FAIL rand_ack cyc=%0d got=%b expected=%b", k, bus.ack, want);
            end
            checks++;
            if (bus.fifo_wr_req !== m_valid || (m_valid && bus.fifo_wr_port !== m_word) || bus.stall_cnt !== m_stall) begin
                errors++;
                $display("FAIL rand_out cyc=%0d wr_req=%b port=%h stall=%0d expected %b/%h/%0d",
                         k, bus.fifo_wr_req, bus.fifo_wr_port, bus.stall_cnt, m_valid, m_word, m_stall);
            end
            for (int i = 0; i < NREQ; i++) begin
                if (bus.ack[i]) begin
                    checks++;
                    if (waited[i] > NREQ - 1) begin
                        errors++; $display("FAIL rand_fair core=%0d waited=%0d grants, limit=%0d", i, waited[i], NREQ - 1);
                    end
                    waited[i] = 0;
                end else if (!pending[i]) begin
                    waited[i] = 0;
                end else if (bus.ack != '0) begin
                    waited[i]++;
                end
            end
            last_ack = bus.ack;
        end
    endtask

    initial begin
        bus.req = '0;
        bus.req_data = '0;
        bus.fifo_q_full = 1'b0;
        test_reset();
        test_round_robin();
        test_single();
        test_full_stall();
        test_stall_sat();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
